// File: rtl/xswitch_port_rx.sv
// xswitch_port_rx: drains one xswitch output port. It issues one-cycle rd_en
// strobes while the switch reports a pending word, checks each returned word
// against the port's own address, and queues accepted words in a small FIFO
// that is presented as a valid/ready stream.
module xswitch_port_rx #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_en,
  input  logic [ADDR_W-1:0]      my_addr,
  input  logic                   data_rdy,
  input  logic [DATA_W-1:0]      data_out,
  input  logic [ADDR_W-1:0]      addr_out,
  output logic                   rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   addr_err,
  input  logic                   err_clr,
  output logic [15:0]            word_cnt,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // FIFO is full at DEPTH entries.
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  // Chaining a new read from CAP needs room for the word being captured now
  // plus the word the next read will bring back.
  localparam logic [LVL_W-1:0] LVL_CHAIN = LVL_W'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2
  } state_e;

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e            state_q;
  logic              rd_en_q;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic              addr_err_q, addr_err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;

  logic              can_start;
  logic              can_chain;
  logic              cap;
  logic              addr_match;
  logic              push;
  logic              drop;
  logic              pop;
  logic              head_valid;

  assign can_start  = rx_en & data_rdy & (level_q < LVL_FULL);
  assign can_chain  = rx_en & data_rdy & (level_q <= LVL_CHAIN);
  assign cap        = (state_q == S_CAP);
  assign addr_match = (addr_out == my_addr);
  assign push       = cap & addr_match;
  assign drop       = cap & ~addr_match;
  assign head_valid = (level_q != '0);
  assign pop        = head_valid & m_ready;

  // Read-strobe FSM; rd_en is registered and high exactly while in S_RD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (can_start) begin
            state_q <= S_RD;
            rd_en_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
          end
        end
        S_RD: begin
          state_q <= S_CAP;
          rd_en_q <= 1'b0;
        end
        S_CAP: begin
          if (can_chain) begin
            state_q <= S_RD;
            rd_en_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; written only on an accepted capture, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= data_out;
      mem_addr_q[wr_ptr_q] <= addr_out;
    end
  end

  // Next-state for FIFO pointers, occupancy and the held head value.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    last_data_d = last_data_q;
    last_addr_d = last_addr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      last_data_d = mem_data_q[rd_ptr_q];
      last_addr_d = mem_addr_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_data_q <= '0;
      last_addr_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      last_data_q <= last_data_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Next-state for status: a mismatch in the same cycle as err_clr wins.
  always_comb begin
    addr_err_d = addr_err_q;
    drop_cnt_d = drop_cnt_q;
    word_cnt_d = word_cnt_q;
    if (drop) begin
      addr_err_d = 1'b1;
      drop_cnt_d = err_clr ? 8'd1 : sat_inc8(drop_cnt_q);
    end else if (err_clr) begin
      addr_err_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
    if (push) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      word_cnt_q <= 16'd0;
    end else begin
      addr_err_q <= addr_err_d;
      drop_cnt_q <= drop_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // When empty the stream outputs keep the last popped word (0 after reset).
  assign rd_en    = rd_en_q;
  assign m_valid  = head_valid;
  assign m_data   = head_valid ? mem_data_q[rd_ptr_q] : last_data_q;
  assign m_addr   = head_valid ? mem_addr_q[rd_ptr_q] : last_addr_q;
  assign level    = level_q;
  assign addr_err = addr_err_q;
  assign drop_cnt = drop_cnt_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_xswitch_port_rx.sv
// Directed bench for xswitch_port_rx: a tiny switch model answers each rd_en
// with the next queued word one cycle later, and a monitor records every
// stream handshake so order and content can be checked.
module tb_xswitch_port_rx;

  logic        clk;
  logic        reset;
  logic        rx_en;
  logic [15:0] my_addr;
  logic        data_rdy;
  logic [15:0] data_out;
  logic [15:0] addr_out;
  logic        rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [15:0] m_addr;
  logic [2:0]  level;
  logic        addr_err;
  logic        err_clr;
  logic [15:0] word_cnt;
  logic [7:0]  drop_cnt;

  xswitch_port_rx #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_en    (rx_en),
    .my_addr  (my_addr),
    .data_rdy (data_rdy),
    .data_out (data_out),
    .addr_out (addr_out),
    .rd_en    (rd_en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_addr   (m_addr),
    .level    (level),
    .addr_err (addr_err),
    .err_clr  (err_clr),
    .word_cnt (word_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rd_cnt   = 0;
  int          cyc      = 0;
  int          last_rd  = -1;
  bit          gap_bad  = 0;
  bit          prev_rd  = 0;
  int          lvl_max  = 0;
  logic [31:0] sw_q [$];
  logic [31:0] got  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes, advance, sample at +1, then play the switch.
  task automatic step();
    if (m_valid === 1'b1 && m_ready === 1'b1) got.push_back({m_addr, m_data});
    @(posedge clk);
    #1;
    cyc++;
    if (rd_en === 1'b1) begin
      if (last_rd >= 0 && (cyc - last_rd) != 2) gap_bad = 1;
      last_rd = cyc;
      rd_cnt++;
    end
    if (int'(level) > lvl_max) lvl_max = int'(level);
    if (prev_rd && sw_q.size() > 0) begin
      {addr_out, data_out} = sw_q.pop_front();
    end else begin
      data_out = 16'hDEAD;
      addr_out = ~my_addr;
    end
    prev_rd = (rd_en === 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    sw_q.delete();
    got.delete();
    prev_rd = 0;
  endtask

  initial begin
    reset    = 1'b0;
    rx_en    = 1'b0;
    my_addr  = 16'h0002;
    data_rdy = 1'b0;
    data_out = 16'h0000;
    addr_out = 16'h0000;
    m_ready  = 1'b0;
    err_clr  = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_level", level, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b1;

    // rx_en low: no reads even with data pending
    rd_cnt   = 0;
    data_rdy = 1'b1;
    repeat (4) step();
    chk("rx_off_no_rd", rd_cnt, 0);
    data_rdy = 1'b0;
    rx_en    = 1'b1;
    step();

    // Single word
    got.delete();
    sw_q.push_back({16'h0002, 16'hBEEF});
    rd_cnt   = 0;
    data_rdy = 1'b1;
    step();
    chk("single_rd_t1", rd_en, 1);
    data_rdy = 1'b0;
    step();
    chk("single_nvld_t2", m_valid, 0);
    step();
    chk("single_vld_t3", m_valid, 1);
    chk("single_data", m_data, 16'hBEEF);
    chk("single_addr", m_addr, 16'h0002);
    chk("single_level", level, 1);
    chk("single_wcnt", word_cnt, 1);
    repeat (3) step();
    chk("single_rd_cnt", rd_cnt, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("single_pop_level", level, 0);
    chk("single_pop_nvld", m_valid, 0);
    chk("single_hold_data", m_data, 16'hBEEF);
    chk("single_got_n", got.size(), 1);

    // Streaming 8 words
    pulse_reset();
    for (int i = 0; i < 8; i++) sw_q.push_back({16'h0002, 16'h1000 + 16'(i)});
    rd_cnt   = 0;
    last_rd  = -1;
    gap_bad  = 0;
    lvl_max  = 0;
    m_ready  = 1'b1;
    data_rdy = 1'b1;
    for (int i = 0; i < 40 && rd_cnt < 8; i++) step();
    data_rdy = 1'b0;
    repeat (6) step();
    chk("stream_rd_cnt", rd_cnt, 8);
    chk("stream_gap2", gap_bad, 0);
    chk("stream_lvl_le2", (lvl_max <= 2), 1);
    chk("stream_wcnt", word_cnt, 8);
    chk("stream_got_n", got.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("stream_word%0d", i), (i < got.size()) ? got[i] : 32'hFFFFFFFF,
          {16'h0002, 16'h1000 + 16'(i)});
    chk("stream_level0", level, 0);

    // Backpressure
    pulse_reset();
    for (int i = 0; i < 5; i++) sw_q.push_back({16'h0002, 16'h2000 + 16'(i)});
    rd_cnt   = 0;
    m_ready  = 1'b0;
    data_rdy = 1'b1;
    repeat (20) step();
    chk("bp_rd_cnt4", rd_cnt, 4);
    chk("bp_level4", level, 4);
    chk("bp_head", m_data, 16'h2000);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("bp_level3", level, 3);
    chk("bp_head2", m_data, 16'h2001);
    step();
    chk("bp_fifth_rd", rd_en, 1);
    chk("bp_rd_cnt5", rd_cnt, 5);
    data_rdy = 1'b0;
    step();
    step();
    chk("bp_level4b", level, 4);
    m_ready = 1'b1;
    repeat (6) step();
    m_ready = 1'b0;
    chk("bp_drained", level, 0);
    chk("bp_got_n", got.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_word%0d", i), (i < got.size()) ? got[i] : 32'hFFFFFFFF,
          {16'h0002, 16'h2000 + 16'(i)});

    // Address mismatch
    sw_q.push_back({16'h0004, 16'h5555});
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    repeat (3) step();
    chk("mm_no_vld", m_valid, 0);
    chk("mm_level", level, 0);
    chk("mm_err", addr_err, 1);
    chk("mm_drop1", drop_cnt, 1);
    chk("mm_wcnt", word_cnt, 5);
    sw_q.push_back({16'h0004, 16'h6666});
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    repeat (3) step();
    chk("mm_drop2", drop_cnt, 2);
    sw_q.push_back({16'h0004, 16'h7777});
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("mm_clr_set_err", addr_err, 1);
    chk("mm_clr_set_cnt", drop_cnt, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("mm_clr_err", addr_err, 0);
    chk("mm_clr_cnt", drop_cnt, 0);
    chk("mm_clr_wcnt", word_cnt, 5);

    // Simultaneous push and pop at level 2
    got.delete();
    for (int i = 0; i < 3; i++) sw_q.push_back({16'h0002, 16'h3000 + 16'(i)});
    rd_cnt   = 0;
    m_ready  = 1'b0;
    data_rdy = 1'b1;
    for (int i = 0; i < 10 && rd_cnt < 2; i++) step();
    data_rdy = 1'b0;
    repeat (3) step();
    chk("pp_level2", level, 2);
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pp_level_same", level, 2);
    chk("pp_head", m_data, 16'h3001);
    m_ready = 1'b1;
    repeat (4) step();
    m_ready = 1'b0;
    chk("pp_got_n", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("pp_word%0d", i), (i < got.size()) ? got[i] : 32'hFFFFFFFF,
          {16'h0002, 16'h3000 + 16'(i)});
    chk("pp_wcnt", word_cnt, 8);

    // Reset while rd_en is high
    sw_q.push_back({16'h0002, 16'h7777});
    data_rdy = 1'b1;
    step();
    chk("rrd_rd_en", rd_en, 1);
    reset = 1'b0;
    #1;
    data_rdy = 1'b0;
    chk("rrd_rd_low", rd_en, 0);
    chk("rrd_m_valid", m_valid, 0);
    chk("rrd_m_data", m_data, 0);
    chk("rrd_m_addr", m_addr, 0);
    chk("rrd_level", level, 0);
    chk("rrd_wcnt", word_cnt, 0);
    chk("rrd_drop", drop_cnt, 0);
    sw_q.delete();
    prev_rd = 0;
    step();
    step();
    reset = 1'b1;
    step();
    sw_q.push_back({16'h0002, 16'hCAFE});
    rd_cnt   = 0;
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    step();
    step();
    chk("rst_again_vld", m_valid, 1);
    chk("rst_again_data", m_data, 16'hCAFE);
    chk("rst_again_wcnt", word_cnt, 1);
    step();
    chk("rst_again_rd_cnt", rd_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
